btn_conditioner: RTL

Parametrised multi-channel push-button front end. It is the successor to the per-button debouncer instances fed by a separate divided clock. It runs entirely on the system clock and uses an internal sample-tick enable instead of a divided clock. Each channel provides a debounced level, one-clock press and release pulses, a long-press pulse and an optional auto-repeat. It sits between the board pins and the application FSM (e.g. atm).

---
 rtl/btn_defs_pkg.sv | 18 +
 rtl/btn_channel.sv | 135 +++++++++++++
 rtl/btn_conditioner.sv | 61 ++++++
 3 files changed

// File: rtl/btn_defs_pkg.sv
// Shared definitions for the push-button front end: FSM state encodings
// and a width helper that never returns less than one bit.
package btn_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_t;

  // Counter width for a counter that must reach value-1; at least 1 bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, tick-gated debounce counter,
// press/release/long-press pulse registers and the hold/repeat FSM.
module btn_channel
  import btn_defs_pkg::*;
#(
  parameter int DEB_TICKS    = 4,
  parameter int HOLD_TICKS   = 250,
  parameter int REPEAT_TICKS = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic noisy,
  input  logic tick,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic released,
  output logic long_press
);

  localparam int DEB_W = clog2_min1(DEB_TICKS);
  localparam int HOLD_W = clog2_min1(HOLD_TICKS);
  localparam int REP_W = clog2_min1(REPEAT_TICKS);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);

  logic [1:0]        sync_reg;
  logic              s;
  logic [DEB_W-1:0]  deb_cnt_reg;
  logic [DEB_W-1:0]  deb_cnt_next;
  logic              level_reg;
  logic              level_next;
  logic              rise_evt;
  logic              fall_evt;
  btn_state_t        state_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [REP_W-1:0]  rep_cnt_reg;
  logic              press_reg;
  logic              release_reg;
  logic              long_reg;

  assign s = sync_reg[1];

  // Debounce decision for this tick: an agreeing sample clears the count,
  // DEB_TICKS consecutive disagreeing samples flip the level.
  always_comb begin
    deb_cnt_next = deb_cnt_reg;
    level_next   = level_reg;
    rise_evt     = 1'b0;
    fall_evt     = 1'b0;
    if (tick) begin
      if (s == level_reg) begin
        deb_cnt_next = '0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        deb_cnt_next = '0;
        level_next   = s;
        rise_evt     = s;
        fall_evt     = ~s;
      end else begin
        deb_cnt_next = deb_cnt_reg + 1'b1;
      end
    end
  end

  // Synchroniser and debounced level state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg    <= 2'b00;
      deb_cnt_reg <= '0;
      level_reg   <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], noisy};
      deb_cnt_reg <= deb_cnt_next;
      level_reg   <= level_next;
    end
  end

  // Hold/repeat FSM with registered pulses; a release on the same tick as
  // a hold expiry or a repeat suppresses the long_press/repeat pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      hold_cnt_reg <= '0;
      rep_cnt_reg  <= '0;
      press_reg    <= 1'b0;
      release_reg  <= 1'b0;
      long_reg     <= 1'b0;
    end else begin
      press_reg   <= rise_evt;
      release_reg <= fall_evt;
      long_reg    <= 1'b0;
      if (tick) begin
        case (state_reg)
          ST_IDLE: begin
            if (rise_evt) begin
              state_reg    <= ST_PRESSED;
              hold_cnt_reg <= '0;
            end
          end
          ST_PRESSED: begin
            if (fall_evt) begin
              state_reg <= ST_IDLE;
            end else if (hold_cnt_reg == HOLD_LAST) begin
              long_reg    <= 1'b1;
              state_reg   <= ST_HELD;
              rep_cnt_reg <= '0;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
          end
          ST_HELD: begin
            if (fall_evt) begin
              state_reg <= ST_IDLE;
            end else if (!repeat_en) begin
              rep_cnt_reg <= '0;
            end else if (rep_cnt_reg == REP_LAST) begin
              press_reg   <= 1'b1;
              rep_cnt_reg <= '0;
            end else begin
              rep_cnt_reg <= rep_cnt_reg + 1'b1;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign level      = level_reg;
  assign press      = press_reg;
  assign released   = release_reg;
  assign long_press = long_reg;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end running on the system clock.
// A shared counter produces a one-clk sample tick every TICK_DIV clocks;
// each channel is an independent btn_channel. "release" is a reserved
// word, so the release pulse port is named released.
module btn_conditioner
  import btn_defs_pkg::*;
#(
  parameter int N_CH         = 3,
  parameter int TICK_DIV     = 50000,
  parameter int DEB_TICKS    = 4,
  parameter int HOLD_TICKS   = 250,
  parameter int REPEAT_TICKS = 50
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] noisy_in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] released,
  output logic [N_CH-1:0] long_press,
  output logic            tick
);

  localparam int TICK_W = clog2_min1(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_cnt_reg;

  // Free-running sample counter, 0..TICK_DIV-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_reg <= '0;
    end else if (tick_cnt_reg == TICK_LAST) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end

  assign tick = (tick_cnt_reg == TICK_LAST);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    btn_channel #(
      .DEB_TICKS   (DEB_TICKS),
      .HOLD_TICKS  (HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .noisy     (noisy_in[gi]),
      .tick      (tick),
      .repeat_en (repeat_en[gi]),
      .level     (level[gi]),
      .press     (press[gi]),
      .released  (released[gi]),
      .long_press(long_press[gi])
    );
  end

endmodule
